// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port, registered-read RAM between the
// instruction-fetch port and the load/store port. Each access takes four cycles.
module mem_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic              clkd,
   input  logic              RESET,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wmask,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              grant_d
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t state;
   logic   prio;     // side that wins a tie: 1 = data, 0 = fetch
   logic   pick_d;

   assign pick_d = d_req & (~i_req | prio);
   assign busy   = (state != IDLE);

   // Byte-offset and out-of-range address bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                               d_addr[31:ADDR_W+2], d_addr[1:0]};

   // NOTE: every register here uses non-blocking assignment so all state updates
   // see the pre-edge values, independent of statement order.
   always_ff @(posedge clkd or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         prio      <= 1'b0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         mem_wmask <= 4'b0000;
         mem_wdata <= 32'h0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= 32'h0;
         d_rdata   <= 32'h0;
         grant_d   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  grant_d   <= pick_d;
                  prio      <= ~pick_d;
                  mem_en    <= 1'b1;
                  mem_addr  <= pick_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                  mem_wmask <= pick_d ? d_wmask : 4'b0000;
                  mem_wdata <= pick_d ? d_wdata : 32'h0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               // The RAM's registered read data is valid during this cycle.
               if (grant_d) begin
                  if (mem_wmask == 4'b0000) d_rdata <= mem_rdata;
                  d_ack <= 1'b1;
               end else begin
                  i_rdata <= mem_rdata;
                  i_ack   <= 1'b1;
               end
               state <= ACK;
            end
            ACK: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
